// File: rtl/dm_bus_pkg.sv
// Shared definitions for the CPU data-memory request/response bus.
// State encodings, bus widths and the default wait-state count live here.
package dm_bus_pkg;

  localparam int DM_ADDR_W       = 10;
  localparam int DM_DATA_W       = 32;
  localparam int DM_BE_W         = 4;
  localparam int DM_WAIT_CYCLES  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dm_state_t;

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [DM_DATA_W-1:0] rdata;
  } dm_rsp_t;

  // Counter preload for the WAIT state; zero wait states never enter WAIT.
  function automatic logic [3:0] wait_init(input int wc);
    return (wc > 0) ? 4'(wc - 1) : 4'd0;
  endfunction

endpackage

// File: rtl/dm_resp_ctrl_if.sv
// Data-memory request/response bus between the core load/store path and the responder.
interface dm_resp_ctrl_if #(parameter int ADDR_W = dm_bus_pkg::DM_ADDR_W);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_we;
  logic [31:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_we, rsp_rdata
  );
endinterface

// File: rtl/dm_array.sv
// Word-addressed data store: one byte-wide bank per lane, synchronous
// byte-enabled write, combinational read. Contents are never reset.
module dm_array
  import dm_bus_pkg::*;
#(
  parameter int ADDR_W    = DM_ADDR_W,
  parameter int NUM_LANES = DM_BE_W
) (
  input  logic                      clk,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [NUM_LANES-1:0][7:0] din,
  input  logic [NUM_LANES-1:0]      be,
  input  logic                      we,
  output logic [NUM_LANES-1:0][7:0] dout
);

  localparam int DEPTH = 1 << ADDR_W;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we && be[l]) mem[addr] <= din[l];
    end

    assign dout[l] = mem[addr];
  end

endmodule

// File: rtl/dm_resp_ctrl.sv
// Data-memory responder: accepts one request at a time, inserts WAIT_CYCLES
// wait states, commits to dm_array and returns data/ack on the response channel.
module dm_resp_ctrl
  import dm_bus_pkg::*;
#(
  parameter int ADDR_W      = DM_ADDR_W,
  parameter int WAIT_CYCLES = DM_WAIT_CYCLES
) (
  input  logic           clk,
  input  logic           rst,
  dm_resp_ctrl_if.slave  bus
);

  localparam logic [3:0] CNT_INIT = wait_init(WAIT_CYCLES);
  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);

  dm_state_t         state, nxt;
  logic [3:0]        cnt;
  logic              accept, commit, in_idle;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [3:0]        lat_be;

  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic [3:0]        c_be;
  logic [31:0]       arr_dout;

  dm_rsp_t           rsp;

  assign in_idle       = (state == S_IDLE);
  assign accept        = bus.req_valid & in_idle;
  assign bus.req_ready = in_idle;
  assign bus.rsp_valid = rsp.valid;
  assign bus.rsp_we    = rsp.we;
  assign bus.rsp_rdata = rsp.rdata;

  // A commit from IDLE only happens with zero wait states, before the latch
  // has loaded, so it must take the live request fields.
  assign c_we    = in_idle ? bus.req_we    : lat_we;
  assign c_addr  = in_idle ? bus.req_addr  : lat_addr;
  assign c_wdata = in_idle ? bus.req_wdata : lat_wdata;
  assign c_be    = in_idle ? bus.req_be    : lat_be;

  dm_array #(.ADDR_W(ADDR_W), .NUM_LANES(DM_BE_W)) u_array (
    .clk  (clk),
    .addr (c_addr),
    .din  (c_wdata),
    .be   (c_be),
    .we   (commit & c_we),
    .dout (arr_dout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt    = state;
    commit = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (NO_WAIT) begin
            commit = 1'b1;
            nxt    = S_RESP;
          end else begin
            nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          commit = 1'b1;
          nxt    = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rsp       <= '0;
    end else begin
      if (accept) begin
        lat_we    <= bus.req_we;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        lat_be    <= bus.req_be;
        cnt       <= CNT_INIT;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (commit) begin
        rsp.valid <= 1'b1;
        rsp.we    <= c_we;
        rsp.rdata <= c_we ? 32'h0 : arr_dout;
      end else if (state == S_RESP && bus.rsp_ready) begin
        rsp.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dm_resp_ctrl.sv
// Bench for dm_resp_ctrl: one responder with two wait states (index 0) and one
// with none (index 1), checked against a word-level memory model.
module tb_dm_resp_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dm_resp_ctrl_if #(.ADDR_W(10)) if2 ();
  dm_resp_ctrl_if #(.ADDR_W(10)) if0 ();

  dm_resp_ctrl #(.ADDR_W(10), .WAIT_CYCLES(2)) u_w2 (.clk(clk), .rst(rst), .bus(if2));
  dm_resp_ctrl #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .rst(rst), .bus(if0));

  logic [1:0]  req_valid_d = '0, req_we_d = '0, rsp_ready_d = 2'b11;
  logic [9:0]  req_addr_d  [2] = '{default: '0};
  logic [31:0] req_wdata_d [2] = '{default: '0};
  logic [3:0]  req_be_d    [2] = '{default: '0};
  logic [1:0]  req_ready_o, rsp_valid_o, rsp_we_o;
  logic [31:0] rsp_rdata_o [2];

  assign if2.req_valid = req_valid_d[0];  assign if0.req_valid = req_valid_d[1];
  assign if2.req_we    = req_we_d[0];     assign if0.req_we    = req_we_d[1];
  assign if2.req_addr  = req_addr_d[0];   assign if0.req_addr  = req_addr_d[1];
  assign if2.req_wdata = req_wdata_d[0];  assign if0.req_wdata = req_wdata_d[1];
  assign if2.req_be    = req_be_d[0];     assign if0.req_be    = req_be_d[1];
  assign if2.rsp_ready = rsp_ready_d[0];  assign if0.rsp_ready = rsp_ready_d[1];
  assign req_ready_o[0] = if2.req_ready;  assign req_ready_o[1] = if0.req_ready;
  assign rsp_valid_o[0] = if2.rsp_valid;  assign rsp_valid_o[1] = if0.rsp_valid;
  assign rsp_we_o[0]    = if2.rsp_we;     assign rsp_we_o[1]    = if0.rsp_we;
  assign rsp_rdata_o[0] = if2.rsp_rdata;  assign rsp_rdata_o[1] = if0.rsp_rdata;

  int vec  = 0;
  int miss = 0;

  // Reference model: one word per (responder, address); absent means never written.
  logic [31:0] mdl [int];

  function automatic int wc(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] mread(input int k, input logic [9:0] a);
    int key = k * 4096 + int'(a);
    return mdl.exists(key) ? mdl[key] : 32'hxxxx_xxxx;
  endfunction

  function automatic void mwrite(input int k, input logic [9:0] a,
                                 input logic [31:0] d, input logic [3:0] be);
    int key = k * 4096 + int'(a);
    logic [31:0] w = mdl.exists(key) ? mdl[key] : 32'hxxxx_xxxx;
    for (int i = 0; i < 4; i++)
      if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    mdl[key] = w;
  endfunction

  // One complete transaction; entered and left just after a rising edge.
  // lat = edges after the accept edge until rsp_valid is seen high.
  task automatic txn(input int k, input logic we, input logic [9:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input int hold,
                     output logic [31:0] rd, output logic rwe, output int lat);
    int n = 0;
    while (!req_ready_o[k] && n < 50) begin @(posedge clk); #1; n++; end
    vec++;
    if (!req_ready_o[k]) begin miss++; $display("FAIL txn_ready_timeout[%0d]: req_ready=%b required 1", k, req_ready_o[k]); end
    req_valid_d[k] = 1'b1; req_we_d[k] = we; req_addr_d[k] = a;
    req_wdata_d[k] = wd;   req_be_d[k] = be; rsp_ready_d[k] = (hold == 0);
    @(posedge clk); #1;
    req_valid_d[k] = 1'b0;
    lat = 0;
    while (!rsp_valid_o[k] && lat < 50) begin @(posedge clk); #1; lat++; end
    vec++;
    if (!rsp_valid_o[k]) begin miss++; $display("FAIL txn_rsp_timeout[%0d]: rsp_valid=%b required 1", k, rsp_valid_o[k]); end
    rd  = rsp_rdata_o[k];
    rwe = rsp_we_o[k];
    repeat (hold) begin @(posedge clk); #1; end
    rsp_ready_d[k] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      vec++; if (req_ready_o[k] !== 1'b1) begin miss++; $display("FAIL reset_req_ready[%0d]: got %b want 1", k, req_ready_o[k]); end
      vec++; if (rsp_valid_o[k] !== 1'b0) begin miss++; $display("FAIL reset_rsp_valid[%0d]: got %b want 0", k, rsp_valid_o[k]); end
      vec++; if (rsp_rdata_o[k] !== 32'h0) begin miss++; $display("FAIL reset_rsp_rdata[%0d]: got %h want 0", k, rsp_rdata_o[k]); end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic rwe; int lat;
    for (int k = 0; k < 2; k++) begin
      txn(k, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 0, rd, rwe, lat);
      mwrite(k, 10'h010, 32'hDEADBEEF, 4'hF);
      vec++; if (lat != wc(k)) begin miss++; $display("FAIL wr_latency[%0d]: got %0d want %0d", k, lat, wc(k)); end
      vec++; if (rwe !== 1'b1) begin miss++; $display("FAIL wr_rsp_we[%0d]: got %b want 1", k, rwe); end
      vec++; if (rd !== 32'h0) begin miss++; $display("FAIL wr_rsp_rdata[%0d]: got %h want 0", k, rd); end
      vec++; if (req_ready_o[k] !== 1'b1 || rsp_valid_o[k] !== 1'b0) begin miss++; $display("FAIL wr_back_idle[%0d]: ready=%b valid=%b want 1/0", k, req_ready_o[k], rsp_valid_o[k]); end
      txn(k, 1'b0, 10'h010, 32'h0, 4'h0, 0, rd, rwe, lat);
      vec++; if (rd !== mread(k, 10'h010)) begin miss++; $display("FAIL rd_data[%0d]: got %h want %h", k, rd, mread(k, 10'h010)); end
      vec++; if (rwe !== 1'b0) begin miss++; $display("FAIL rd_rsp_we[%0d]: got %b want 0", k, rwe); end
      vec++; if (lat != wc(k)) begin miss++; $display("FAIL rd_latency[%0d]: got %0d want %0d", k, lat, wc(k)); end
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd; logic rwe; int lat;
    txn(0, 1'b1, 10'h3FF, 32'h11223344, 4'hF, 0, rd, rwe, lat); mwrite(0, 10'h3FF, 32'h11223344, 4'hF);
    txn(0, 1'b1, 10'h3FF, 32'hAABBCCDD, 4'b0101, 0, rd, rwe, lat); mwrite(0, 10'h3FF, 32'hAABBCCDD, 4'b0101);
    txn(0, 1'b0, 10'h3FF, 32'h0, 4'h0, 0, rd, rwe, lat);
    vec++; if (rd !== 32'h11BB33DD) begin miss++; $display("FAIL be_0101: got %h want 11bb33dd", rd); end
    txn(0, 1'b1, 10'h3FF, 32'hFFFFFFFF, 4'b0000, 0, rd, rwe, lat);
    vec++; if (rwe !== 1'b1 || lat != 2) begin miss++; $display("FAIL be_zero_ack: we=%b lat=%0d want 1/2", rwe, lat); end
    txn(0, 1'b0, 10'h3FF, 32'h0, 4'h0, 0, rd, rwe, lat);
    vec++; if (rd !== mread(0, 10'h3FF)) begin miss++; $display("FAIL be_zero_nochange: got %h want %h", rd, mread(0, 10'h3FF)); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic rwe; int lat; int n = 0;
    req_valid_d[0] = 1'b1; req_we_d[0] = 1'b0; req_addr_d[0] = 10'h010; rsp_ready_d[0] = 1'b0;
    @(posedge clk); #1;
    // A conflicting write is held pending for the whole response phase.
    req_we_d[0] = 1'b1; req_wdata_d[0] = 32'hCAFEF00D; req_be_d[0] = 4'hF;
    while (!rsp_valid_o[0] && n < 50) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 5; c++) begin
      vec++;
      if (rsp_valid_o[0] !== 1'b1 || rsp_rdata_o[0] !== mread(0, 10'h010) || req_ready_o[0] !== 1'b0) begin
        miss++; $display("FAIL bp_hold[c%0d]: valid=%b rdata=%h ready=%b want 1/%h/0", c, rsp_valid_o[0], rsp_rdata_o[0], req_ready_o[0], mread(0, 10'h010));
      end
      @(posedge clk); #1;
    end
    rsp_ready_d[0] = 1'b1; req_valid_d[0] = 1'b0;
    @(posedge clk); #1;
    vec++; if (rsp_valid_o[0] !== 1'b0 || req_ready_o[0] !== 1'b1) begin miss++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", rsp_valid_o[0], req_ready_o[0]); end
    txn(0, 1'b0, 10'h010, 32'h0, 4'h0, 0, rd, rwe, lat);
    vec++; if (rd !== mread(0, 10'h010)) begin miss++; $display("FAIL bp_not_accepted: got %h want %h", rd, mread(0, 10'h010)); end
  endtask

  task automatic test_back_to_back(input int k);
    int acc[$]; logic r; int n = 0;
    req_valid_d[k] = 1'b1; req_we_d[k] = 1'b0; req_addr_d[k] = 10'h010; rsp_ready_d[k] = 1'b1;
    for (int c = 0; c < 40 && acc.size() < 3; c++) begin
      r = req_ready_o[k];
      @(posedge clk);
      if (r) acc.push_back(c);
      #1;
    end
    req_valid_d[k] = 1'b0;
    while (!(req_ready_o[k] && !rsp_valid_o[k]) && n < 50) begin @(posedge clk); #1; n++; end
    vec++;
    if (acc.size() != 3) begin miss++; $display("FAIL b2b_count[%0d]: got %0d accepts want 3", k, acc.size()); end
    else begin
      vec++; if (acc[1] - acc[0] != wc(k) + 2) begin miss++; $display("FAIL b2b_gap1[%0d]: got %0d want %0d", k, acc[1] - acc[0], wc(k) + 2); end
      vec++; if (acc[2] - acc[1] != wc(k) + 2) begin miss++; $display("FAIL b2b_gap2[%0d]: got %0d want %0d", k, acc[2] - acc[1], wc(k) + 2); end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic rwe; int lat;
    txn(0, 1'b1, 10'h020, 32'h0, 4'hF, 0, rd, rwe, lat); mwrite(0, 10'h020, 32'h0, 4'hF);
    req_valid_d[0] = 1'b1; req_we_d[0] = 1'b1; req_addr_d[0] = 10'h020;
    req_wdata_d[0] = 32'h12345678; req_be_d[0] = 4'hF;
    @(posedge clk); #1;
    req_valid_d[0] = 1'b0;
    #2 rst = 1'b0;
    #1;
    vec++; if (req_ready_o[0] !== 1'b1 || rsp_valid_o[0] !== 1'b0) begin miss++; $display("FAIL rst_wait_idle: ready=%b valid=%b want 1/0", req_ready_o[0], rsp_valid_o[0]); end
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    vec++; if (rsp_valid_o[0] !== 1'b0) begin miss++; $display("FAIL rst_wait_no_rsp: valid=%b want 0", rsp_valid_o[0]); end
    txn(0, 1'b0, 10'h020, 32'h0, 4'h0, 0, rd, rwe, lat);
    vec++; if (rd !== mread(0, 10'h020)) begin miss++; $display("FAIL rst_wait_discard: got %h want %h", rd, mread(0, 10'h020)); end
  endtask

  task automatic test_random();
    logic [9:0] pool [8] = '{10'h000, 10'h001, 10'h080, 10'h100, 10'h155, 10'h2AA, 10'h3FE, 10'h3FF};
    logic [31:0] rd, wd, exp; logic rwe, we; logic [9:0] a; logic [3:0] be; int lat, k, hold;
    for (int kk = 0; kk < 2; kk++)
      for (int i = 0; i < 8; i++) begin
        wd = $urandom;
        txn(kk, 1'b1, pool[i], wd, 4'hF, 0, rd, rwe, lat); mwrite(kk, pool[i], wd, 4'hF);
      end
    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
      a = pool[$urandom_range(0, 7)]; wd = $urandom; be = 4'($urandom_range(0, 15));
      hold = int'($urandom_range(0, 3));
      exp = we ? 32'h0 : mread(k, a);
      txn(k, we, a, wd, be, hold, rd, rwe, lat);
      if (we) mwrite(k, a, wd, be);
      vec++;
      if (rd !== exp || rwe !== we || lat != wc(k)) begin
        miss++; $display("FAIL rand[%0d] k=%0d a=%h: rdata=%h we=%b lat=%0d want %h/%b/%0d", n, k, a, rd, rwe, lat, exp, we, wc(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_backpressure();
    test_back_to_back(0);
    test_back_to_back(1);
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
